x_uart_rx_cfg: RTL and testbench

Configurable UART receiver that replaces the fixed 8N1 receiver in the serial front end of the delay-line design. It supports 5 to 9 data bits, none, even or odd parity, and 1 or 2 stop bits. It rejects false starts and reports parity errors, framing errors and line breaks alongside each received word. It sits directly behind the FPGA RX pin and feeds the command decoder with a one-cycle valid pulse per frame.

---
 rtl/x_uart_rx_cfg_if.sv | 11 +
 rtl/x_uart_rx_cfg.sv | 95 +++++++++
 tb/tb_x_uart_rx_cfg.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/x_uart_rx_cfg_if.sv
// x_uart_rx_cfg_if: serial line in, received word and status out
interface x_uart_rx_cfg_if #(parameter int p_data_bits = 8);
  logic i_rx;
  logic o_valid;
  logic [p_data_bits-1:0] o_data;
  logic o_parity_err;
  logic o_frame_err;
  logic o_break;
  modport master(input i_rx, output o_valid, o_data, o_parity_err, o_frame_err, o_break);
  modport slave(output i_rx, input o_valid, o_data, o_parity_err, o_frame_err, o_break);
endinterface

// File: rtl/x_uart_rx_cfg.sv
// x_uart_rx_cfg: UART receiver, 5-9 data bits, none/even/odd parity, 1-2 stop bits
// X_UART_RX_CFG_MAJORITY_EN: sample points vote 2-of-3 over p2/p3/p4 to reject one-cycle glitches
module x_uart_rx_cfg #(
  parameter int p_clk_hz = 12000000,
  parameter int p_baud = 115200,
  parameter int p_data_bits = 8,
  parameter int p_parity = 0,
  parameter int p_stop_bits = 1
) (
  input logic i_clk,
  input logic i_rst,
  x_uart_rx_cfg_if.master bus
);
  localparam int T = p_clk_hz / p_baud;
  localparam int TW = $clog2(T + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
  state_t st, nxt;
  logic p1, p2, p3, s, fall, wrap, last, par, fe, st0_lo, fs_lo, perr, brk;
  logic [TW-1:0] tmr;
  logic [3:0] idx;
  logic [p_data_bits-1:0] sh;
`ifdef X_UART_RX_CFG_MAJORITY_EN
  logic p4;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {p1, p2, p3, p4} <= '1;
    else {p1, p2, p3, p4} <= {bus.i_rx, p1, p2, p3};
  assign s = (p2 & p3) | (p2 & p4) | (p3 & p4);
`else
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {p1, p2, p3} <= '1;
    else {p1, p2, p3} <= {bus.i_rx, p1, p2};
  assign s = p2;
`endif
  assign fall = !p2 && p3;
  // START runs a half bit so every later sample lands mid-bit
  assign wrap = tmr == TW'(st == START ? T / 2 - 1 : T - 1);
  assign last = idx == 4'(st == STOP ? p_stop_bits - 1 : p_data_bits - 1);
  assign fs_lo = idx == '0 ? !s : st0_lo;
  assign perr = (p_parity != 0) && ((^sh ^ par) ^ (p_parity == 2));
  assign brk = (sh == '0) && ((p_parity == 0) || !par) && fs_lo;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) tmr <= '0;
    else tmr <= (st == IDLE || wrap) ? '0 : tmr + TW'(1);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = fall ? START : IDLE;
      START: nxt = !wrap ? START : s ? IDLE : DATA;
      DATA: nxt = !(wrap && last) ? DATA : (p_parity != 0) ? PARITY : STOP;
      PARITY: nxt = wrap ? STOP : PARITY;
      STOP: nxt = !(wrap && last) ? STOP : s ? IDLE : WAIT_HI;
      WAIT_HI: nxt = s ? IDLE : WAIT_HI;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      fe <= 1'b0;
      st0_lo <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_data <= '0;
      bus.o_parity_err <= 1'b0;
      bus.o_frame_err <= 1'b0;
      bus.o_break <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      if (wrap && st == START) begin
        idx <= '0;
        fe <= 1'b0;
      end
      if (wrap && st == DATA) begin
        sh <= {s, sh[p_data_bits-1:1]};
        idx <= last ? '0 : idx + 4'd1;
      end
      if (wrap && st == PARITY) par <= s;
      if (wrap && st == STOP) begin
        idx <= idx + 4'd1;
        fe <= fe | !s;
        if (idx == '0) st0_lo <= !s;
        if (last) begin
          bus.o_valid <= 1'b1;
          bus.o_data <= sh;
          bus.o_parity_err <= perr;
          bus.o_frame_err <= fe | !s;
          bus.o_break <= brk;
        end
      end
    end
endmodule

// File: tb/tb_x_uart_rx_cfg.sv
// tb_x_uart_rx_cfg: scoreboard bench for an 8N1 receiver and a 7E2 receiver
module tb_x_uart_rx_cfg;
  localparam int T = 12000000 / 115200;
  typedef struct packed {logic [8:0] d; logic pe; logic fe; logic brk;} rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rec_t exp0[$], got0[$], exp1[$], got1[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  x_uart_rx_cfg_if #(.p_data_bits(8)) b0();
  x_uart_rx_cfg_if #(.p_data_bits(7)) b1();
  x_uart_rx_cfg dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));
  x_uart_rx_cfg #(.p_data_bits(7), .p_parity(1), .p_stop_bits(2)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
  always @(negedge clk) begin
    if (b0.o_valid) got0.push_back(rec_t'({1'b0, b0.o_data, b0.o_parity_err, b0.o_frame_err, b0.o_break}));
    if (b1.o_valid) got1.push_back(rec_t'({2'b0, b1.o_data, b1.o_parity_err, b1.o_frame_err, b1.o_break}));
  end
  initial begin
    #900000;
    $display("FAIL watchdog: run did not end, n_cmp=%0d", n_cmp);
    $fatal(1);
  end
  task automatic set_rx(input int dut, input logic v);
    if (dut == 0) b0.i_rx = v;
    else b1.i_rx = v;
  endtask
  task automatic drive_bit(input int dut, input logic v, input bit gl);
    set_rx(dut, v);
    if (gl) begin
      repeat (T / 2) @(negedge clk);
      set_rx(dut, 1'b1);
      @(negedge clk);
      set_rx(dut, v);
      repeat (T - T / 2 - 1) @(negedge clk);
    end else repeat (T) @(negedge clk);
  endtask
  // pmode: 0 no parity bit, 1 correct even parity, 2 inverted even parity
  task automatic send_frame(input int dut, input logic [8:0] d, input int nb, input int pmode,
                            input int nstop, input logic stop_v, input bit gl);
    drive_bit(dut, 1'b0, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(dut, d[i], gl);
    if (pmode != 0) drive_bit(dut, (^d) ^ (pmode == 2), 1'b0);
    for (int i = 0; i < nstop; i++) drive_bit(dut, stop_v, 1'b0);
  endtask
  task automatic push_exp(input int dut, input logic [8:0] d, input logic pe, input logic fe, input logic brk);
    if (dut == 0) exp0.push_back('{d, pe, fe, brk});
    else exp1.push_back('{d, pe, fe, brk});
  endtask
  task automatic get(input int dut, input int budget, output rec_t e, output rec_t g, output bit ok);
    int n = 0;
    ok = 1'b0;
    e = '0;
    g = '1;
    while ((dut == 0 ? got0.size() : got1.size()) == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dut == 0 && got0.size() > 0 && exp0.size() > 0) begin
      ok = 1'b1;
      e = exp0.pop_front();
      g = got0.pop_front();
    end else if (dut == 1 && got1.size() > 0 && exp1.size() > 0) begin
      ok = 1'b1;
      e = exp1.pop_front();
      g = got1.pop_front();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    b0.i_rx = 1'b1;
    b1.i_rx = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({b0.o_valid, b0.o_data, b0.o_parity_err, b0.o_frame_err, b0.o_break} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_dut0: got v=%b d=%h pe=%b fe=%b brk=%b, expected all 0",
               b0.o_valid, b0.o_data, b0.o_parity_err, b0.o_frame_err, b0.o_break);
    end
    n_cmp++;
    if ({b1.o_valid, b1.o_data, b1.o_parity_err, b1.o_frame_err, b1.o_break} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_dut1: got v=%b d=%h pe=%b fe=%b brk=%b, expected all 0",
               b1.o_valid, b1.o_data, b1.o_parity_err, b1.o_frame_err, b1.o_break);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    rec_t e, g;
    bit ok;
    push_exp(0, 9'h55, 0, 0, 0);
    push_exp(0, 9'hA3, 0, 0, 0);
    send_frame(0, 9'h55, 8, 0, 1, 1'b1, 1'b0);
    send_frame(0, 9'hA3, 8, 0, 1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      get(0, 4 * T, e, g, ok);
      n_cmp++;
      if (!ok || g !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got=%h expected=%h received=%0b", i, g, e, ok);
      end
    end
  endtask
  task automatic test_parity();
    rec_t e, g;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      push_exp(1, 9'h2B, i == 1, 0, 0);
      send_frame(1, 9'h2B, 7, i + 1, 2, 1'b1, 1'b0);
      get(1, 4 * T, e, g, ok);
      n_cmp++;
      if (!ok || g !== e) begin
        n_err++;
        $display("FAIL parity_%s: got=%h expected=%h received=%0b", i ? "bad" : "good", g, e, ok);
      end
    end
    repeat (T) @(negedge clk);
  endtask
  task automatic test_frame_err();
    rec_t e, g;
    bit ok;
    push_exp(0, 9'h7E, 0, 1, 0);
    send_frame(0, 9'h7E, 8, 0, 1, 1'b0, 1'b0);
    get(0, 4 * T, e, g, ok);
    n_cmp++;
    if (!ok || g !== e) begin
      n_err++;
      $display("FAIL frame_err: got=%h expected=%h received=%0b", g, e, ok);
    end
    repeat (2 * T) @(negedge clk);
    n_cmp++;
    if (got0.size() != 0) begin
      n_err++;
      $display("FAIL frame_err_wait: got %0d extra frames, expected 0", got0.size());
    end
    set_rx(0, 1'b1);
    repeat (T) @(negedge clk);
    push_exp(0, 9'h3C, 0, 0, 0);
    send_frame(0, 9'h3C, 8, 0, 1, 1'b1, 1'b0);
    get(0, 4 * T, e, g, ok);
    n_cmp++;
    if (!ok || g !== e) begin
      n_err++;
      $display("FAIL frame_err_next: got=%h expected=%h received=%0b", g, e, ok);
    end
  endtask
  task automatic test_break();
    rec_t e, g;
    bit ok;
    push_exp(0, 9'h00, 0, 1, 1);
    set_rx(0, 1'b0);
    repeat (20 * T) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2 * T) @(negedge clk);
    n_cmp++;
    if (got0.size() != 1) begin
      n_err++;
      $display("FAIL break_count: got %0d frames, expected 1", got0.size());
    end
    get(0, 4 * T, e, g, ok);
    n_cmp++;
    if (!ok || g !== e) begin
      n_err++;
      $display("FAIL break: got=%h expected=%h received=%0b", g, e, ok);
    end
    got0.delete();
    push_exp(0, 9'h5A, 0, 0, 0);
    send_frame(0, 9'h5A, 8, 0, 1, 1'b1, 1'b0);
    get(0, 4 * T, e, g, ok);
    n_cmp++;
    if (!ok || g !== e) begin
      n_err++;
      $display("FAIL break_next: got=%h expected=%h received=%0b", g, e, ok);
    end
  endtask
  task automatic test_false_start();
    rec_t e, g;
    bit ok;
    set_rx(0, 1'b0);
    repeat (T / 4) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (T / 2) @(negedge clk);
    n_cmp++;
    if (got0.size() != 0 || b0.o_data !== 8'h5A) begin
      n_err++;
      $display("FAIL false_start: got %0d frames data=%h, expected 0 frames data=5a", got0.size(), b0.o_data);
    end
    push_exp(0, 9'h81, 0, 0, 0);
    send_frame(0, 9'h81, 8, 0, 1, 1'b1, 1'b0);
    get(0, 4 * T, e, g, ok);
    n_cmp++;
    if (!ok || g !== e) begin
      n_err++;
      $display("FAIL false_start_next: got=%h expected=%h received=%0b", g, e, ok);
    end
  endtask
  task automatic test_reset_mid();
    rec_t e, g;
    bit ok;
    logic [7:0] d = 8'hC4;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i], 1'b0);
    set_rx(0, d[3]);
    repeat (T / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({b0.o_valid, b0.o_data, b0.o_parity_err, b0.o_frame_err, b0.o_break} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b d=%h pe=%b fe=%b brk=%b, expected all 0",
               b0.o_valid, b0.o_data, b0.o_parity_err, b0.o_frame_err, b0.o_break);
    end
    @(negedge clk);
    rst = 1'b0;
    set_rx(0, 1'b1);
    repeat (3 * T) @(negedge clk);
    n_cmp++;
    if (got0.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_novalid: got %0d frames, expected 0", got0.size());
    end
    push_exp(0, 9'h11, 0, 0, 0);
    send_frame(0, 9'h11, 8, 0, 1, 1'b1, 1'b0);
    get(0, 4 * T, e, g, ok);
    n_cmp++;
    if (!ok || g !== e) begin
      n_err++;
      $display("FAIL reset_mid_next: got=%h expected=%h received=%0b", g, e, ok);
    end
  endtask
  task automatic test_glitch();
    rec_t e, g;
    bit ok;
`ifdef X_UART_RX_CFG_MAJORITY_EN
    push_exp(0, 9'h00, 0, 0, 0);
`else
    push_exp(0, 9'hFF, 0, 0, 0);
`endif
    send_frame(0, 9'h00, 8, 0, 1, 1'b1, 1'b1);
    get(0, 4 * T, e, g, ok);
    n_cmp++;
    if (!ok || g !== e) begin
      n_err++;
      $display("FAIL glitch: got=%h expected=%h received=%0b", g, e, ok);
    end
  endtask
  initial begin
    b0.i_rx = 1'b1;
    b1.i_rx = 1'b1;
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_break();
    test_false_start();
    test_reset_mid();
    test_glitch();
    repeat (2 * T) @(negedge clk);
    n_cmp++;
    if (got0.size() != 0 || got1.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d/%0d unexpected frames, expected 0/0", got0.size(), got1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
